// File: rtl/phase_timer.sv
// Phase timer for the irrigation sequencer: times each phase in prescaled ticks and
// returns the end-of-phase (sinal) and early-exit (sinalquinze) strobes.
// Build option PHASE_TIMER_FAST_EN bypasses the prescaler so every RUN clock is a tick.
module phase_timer #(
    parameter int CLK_DIV = 50_000_000,
    parameter int CW      = 8,
    parameter int T_ASP   = 30,
    parameter int T_GOT   = 60,
    parameter int T_LIMP  = 20,
    parameter int T_ENCH  = 40,
    parameter int T_ESP   = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          pausa,
    input  logic [1:0]    estado,
    input  logic          casoEsp,
    output logic          sinal,
    output logic          sinalquinze,
    output logic [CW-1:0] restante,
    output logic          ocupado
);

    localparam int              PW         = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam longint          MAXV       = (longint'(1) << CW) - 1;
    localparam bit              ESP_OK     = (T_ESP >= 1) && (longint'(T_ESP) <= MAXV);
    localparam logic [CW-1:0]   ESP_C      = CW'(T_ESP);
    localparam int              T_RAW [0:3] = '{T_ASP, T_GOT, T_LIMP, T_ENCH};

`ifdef PHASE_TIMER_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_WAIT
    } state_t;

    // Duration table indexed by phase code; a zero duration still lasts one tick.
    logic [CW-1:0] dur_tab [0:3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dur
            if (longint'(T_RAW[gi]) > MAXV) begin : g_bad_dur
                $error("phase_timer: phase %0d duration does not fit in CW bits", gi);
            end
            assign dur_tab[gi] = (T_RAW[gi] == 0) ? CW'(1) : CW'(T_RAW[gi]);
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("phase_timer: CLK_DIV must be at least 2");
        end
    endgenerate

    state_t        state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [CW-1:0] rest_q,    rest_d;
    logic [CW-1:0] elapsed_q, elapsed_d;
    logic [1:0]    estado_q,  estado_d;
    logic          fired_q,   fired_d;
    logic          sinal_q,   sinal_d;
    logic          quinze_q,  quinze_d;
    logic          ocup_q,    ocup_d;

    logic          phase_chg;
    logic          presc_wrap;
    logic          timing;
    logic          tick;
    logic [CW-1:0] elapsed_inc;
    logic          esp_hit;
    logic          load_req;

    assign phase_chg   = (estado != estado_q);
    assign presc_wrap  = (presc_q == PRESC_LAST);
    assign timing      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign tick        = timing && !pausa && !phase_chg && (FAST || presc_wrap);
    assign elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + CW'(1);
    assign esp_hit     = ESP_OK && (elapsed_inc == ESP_C) && (elapsed_q != ESP_C);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        rest_d    = rest_q;
        elapsed_d = elapsed_q;
        estado_d  = estado_q;
        fired_d   = fired_q;
        sinal_d   = 1'b0;
        quinze_d  = 1'b0;
        load_req  = 1'b0;

        if (!enable) begin
            state_d   = S_IDLE;
            presc_d   = '0;
            rest_d    = '0;
            elapsed_d = '0;
            fired_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: load_req = 1'b1;
                // LOAD already counts as the first timed clock of the phase.
                S_LOAD, S_RUN: begin
                    if (phase_chg) begin
                        load_req = 1'b1;
                    end else if (!pausa) begin
                        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
                        state_d = S_RUN;
                        if (tick) begin
                            elapsed_d = elapsed_inc;
                            if (rest_q <= CW'(1)) begin
                                rest_d  = '0;
                                state_d = S_DONE;
                                sinal_d = 1'b1;
                            end else begin
                                rest_d = rest_q - CW'(1);
                                if (esp_hit && (estado_q == 2'b01) && casoEsp && !fired_q) begin
                                    quinze_d = 1'b1;
                                    fired_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_WAIT;
                    rest_d  = '0;
                end
                S_WAIT: begin
                    if (phase_chg) begin
                        load_req = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load_req) begin
            state_d   = S_LOAD;
            rest_d    = dur_tab[estado];
            presc_d   = '0;
            elapsed_d = '0;
            estado_d  = estado;
            fired_d   = 1'b0;
        end

        ocup_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            rest_q    <= '0;
            elapsed_q <= '0;
            estado_q  <= 2'b00;
            fired_q   <= 1'b0;
            sinal_q   <= 1'b0;
            quinze_q  <= 1'b0;
            ocup_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            rest_q    <= rest_d;
            elapsed_q <= elapsed_d;
            estado_q  <= estado_d;
            fired_q   <= fired_d;
            sinal_q   <= sinal_d;
            quinze_q  <= quinze_d;
            ocup_q    <= ocup_d;
        end
    end

    assign sinal       = sinal_q;
    assign sinalquinze = quinze_q;
    assign restante    = rest_q;
    assign ocupado     = ocup_q;

endmodule
